contador_bcd_multiplexado: RTL

Parametrised multi-digit BCD up/down counter with a synchronous load, wrap detection and a time-multiplexed seven-segment driver. It replaces the single-digit counter path of the board top level: one block owns the one-second prescaler, the N-digit decimal count, the manual preset and the digit scan. The board top level instantiates it directly from the pin inputs. Reset debouncing stays upstream of this block.

---
 rtl/contador_pkg.sv | 37 +++
 rtl/bcd_digito.sv | 35 +++
 rtl/contador_bcd_multiplexado.sv | 92 +++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared constants and the seven-segment decoder for the multiplexed BCD counter.
// Segment codes are ordered a..g and active-low.
package contador_pkg;

    localparam int BCD_W = 4;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    function automatic logic [0:6] seg_decode(input logic [BCD_W-1:0] d);
        logic [0:6] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digito.sv
// One BCD digit register with synchronous clamped load and up/down step.
// carry is the combinational carry/borrow that steps the next digit.
module bcd_digito
    import contador_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             up,
    input  logic             load,
    input  logic [BCD_W-1:0] load_nib,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    function automatic logic [BCD_W-1:0] sat_bcd(input logic [BCD_W-1:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    assign carry = step && (up ? (digit == 4'd9) : (digit == 4'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= '0;
        end else if (load) begin
            digit <= sat_bcd(load_nib);
        end else if (step) begin
            if (up)
                digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            else
                digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
        end
    end

endmodule

// File: rtl/contador_bcd_multiplexado.sv
// N-digit BCD up/down counter with one-second prescaler, clamped preset,
// wrap pulse and a time-multiplexed active-low seven-segment driver.
module contador_bcd_multiplexado
    import contador_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    direccion,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_value,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    wrap,
    output logic [0:6]              display,
    output logic [DIGITS-1:0]       anode
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  idx;
    logic [DIGITS:0]   step_c;
    logic [BCD_W-1:0]  digit_q [DIGITS];

    assign tick = (tick_cnt == TICK_LAST);

    // Count-tick prescaler: free-running, only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Load blocks the step chain so no carry, and therefore no wrap, can form.
    assign step_c[0] = tick & enable & ~load;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        bcd_digito u_dig (
            .clk      (clk),
            .rst      (rst),
            .step     (step_c[k]),
            .up       (direccion),
            .load     (load),
            .load_nib (load_value[k*BCD_W +: BCD_W]),
            .digit    (digit_q[k]),
            .carry    (step_c[k+1])
        );
        assign count[k*BCD_W +: BCD_W] = digit_q[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wrap <= 1'b0;
        else     wrap <= step_c[DIGITS];
    end

    // Scan prescaler and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Display stage: anode and segments registered together from one index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode   <= ~DIGITS'(1);
            display <= SEG_0;
        end else begin
            anode   <= ~(DIGITS'(1) << idx);
            display <= seg_decode(digit_q[idx]);
        end
    end

endmodule
